// File: rtl/cpu6_bus_controller.sv
// CPU6 external bus cycle controller: one byte per request, SETUP/STROBE/HOLD with wait states and ready.
// Optional strobe timeout is compiled in with `define BUS_TIMEOUT_EN.
module cpu6_bus_controller #(
  parameter int WAIT_STATES    = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_wdata_oe,
  input  logic [7:0]  mem_rdata,
  output logic        mem_rd_n,
  output logic        mem_wr_n,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [3:0]  wait_q, wait_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        oe_q, oe_d;
  logic        rd_n_q, rd_n_d;
  logic        wr_n_q, wr_n_d;
`ifdef BUS_TIMEOUT_EN
  logic [7:0]  to_q, to_d;
  logic        err_q, err_d;
`endif

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    wait_d      = wait_q;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef BUS_TIMEOUT_EN
    to_d        = to_q;
    err_d       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d     = SETUP;
          mem_addr_d  = addr;
          we_d        = we;
          mem_wdata_d = wdata;
        end
      end
      SETUP: begin
        state_d = STROBE;
        wait_d  = 4'(WAIT_STATES);
`ifdef BUS_TIMEOUT_EN
        to_d    = 8'd0;
`endif
      end
      STROBE: begin
        // Ready is only looked at once the minimum wait has been served.
        if (wait_q != 4'd0) begin
          wait_d = wait_q - 4'd1;
        end else if (mem_ready) begin
          state_d = HOLD;
          if (!we_q) rdata_d = mem_rdata;
        end
`ifdef BUS_TIMEOUT_EN
        if (state_d == STROBE) begin
          to_d = to_q + 8'd1;
          if (({1'b0, to_q} + 9'd1) == 9'(TIMEOUT_CYCLES)) begin
            state_d = HOLD;
            err_d   = 1'b1;
            if (!we_q) rdata_d = 8'hFF;
          end
        end
`endif
      end
      HOLD: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    busy_d = (state_d != IDLE);
    done_d = (state_d == HOLD);
    oe_d   = we_d && (state_d != IDLE);
    rd_n_d = !((state_d == STROBE) && !we_d);
    wr_n_d = !((state_d == STROBE) && we_d);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      wait_q      <= 4'd0;
      rdata_q     <= 8'h00;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 8'h00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      oe_q        <= 1'b0;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      wait_q      <= wait_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      oe_q        <= oe_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
    end
  end

`ifdef BUS_TIMEOUT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      to_q  <= 8'd0;
      err_q <= 1'b0;
    end else begin
      to_q  <= to_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign rdata        = rdata_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_wdata_oe = oe_q;
  assign mem_rd_n     = rd_n_q;
  assign mem_wr_n     = wr_n_q;

endmodule

// File: tb/tb_cpu6_bus_controller.sv
// Directed bench for cpu6_bus_controller: two instances (WAIT_STATES=0 and 2), table vectors plus corner sequences.
module tb_cpu6_bus_controller;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        req [2];
  logic        we [2];
  logic [15:0] addr [2];
  logic [7:0]  wdata [2];
  logic [7:0]  mem_rdata [2];
  logic        mem_ready [2];
  wire  [7:0]  rdata [2];
  wire         busy [2];
  wire         done [2];
  wire         err [2];
  wire  [15:0] mem_addr [2];
  wire  [7:0]  mem_wdata [2];
  wire         oe [2];
  wire         rd_n [2];
  wire         wr_n [2];

  cpu6_bus_controller #(.WAIT_STATES(0), .TIMEOUT_CYCLES(8)) dut0 (
    .clock(clock), .reset(reset), .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
    .rdata(rdata[0]), .busy(busy[0]), .done(done[0]), .err(err[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_wdata_oe(oe[0]), .mem_rdata(mem_rdata[0]),
    .mem_rd_n(rd_n[0]), .mem_wr_n(wr_n[0]), .mem_ready(mem_ready[0]));

  cpu6_bus_controller #(.WAIT_STATES(2), .TIMEOUT_CYCLES(8)) dut2 (
    .clock(clock), .reset(reset), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
    .rdata(rdata[1]), .busy(busy[1]), .done(done[1]), .err(err[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_wdata_oe(oe[1]), .mem_rdata(mem_rdata[1]),
    .mem_rd_n(rd_n[1]), .mem_wr_n(wr_n[1]), .mem_ready(mem_ready[1]));

  typedef struct {
    int          sel;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  mrdata;
    logic [31:0] mask;      // mem_ready value per cycle after the req edge
    int          exp_strobe;
    int          exp_done;
    logic [7:0]  exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [6];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int s;
    int strobe_lo, other_lo, addr_bad, wd_bad, busy_bad, done_at;
    logic got_err;
    s = v.sel;
    strobe_lo = 0; other_lo = 0; addr_bad = 0; wd_bad = 0; busy_bad = 0; done_at = 0;
    got_err = 1'b0;
    @(negedge clock);
    addr[s] = v.addr; we[s] = v.we; wdata[s] = v.wdata; mem_rdata[s] = v.mrdata;
    mem_ready[s] = v.mask[0]; req[s] = 1'b1;
    @(posedge clock); #1;
    req[s] = 1'b0;
    for (int k = 1; k < 30; k++) begin
      mem_ready[s] = v.mask[k];
      @(negedge clock);
      if (v.we ? !wr_n[s] : !rd_n[s]) strobe_lo++;
      if (v.we ? !rd_n[s] : !wr_n[s]) other_lo++;
      if (mem_addr[s] !== v.addr) addr_bad++;
      if (v.we && (mem_wdata[s] !== v.wdata || oe[s] !== 1'b1)) wd_bad++;
      if (!v.we && oe[s] !== 1'b0) wd_bad++;
      if (busy[s] !== 1'b1) busy_bad++;
      if (done[s] === 1'b1) begin
        done_at = k;
        got_err = err[s];
        break;
      end
      @(posedge clock); #1;
    end
    check({tag, "_done_cycle"}, done_at, v.exp_done);
    check({tag, "_strobe_len"}, strobe_lo, v.exp_strobe);
    check({tag, "_other_strobe"}, other_lo, 0);
    check({tag, "_addr_hold"}, addr_bad, 0);
    check({tag, "_wdata_oe"}, wd_bad, 0);
    check({tag, "_busy"}, busy_bad, 0);
    check({tag, "_err"}, got_err, v.exp_err);
    @(posedge clock); #1;
    mem_ready[s] = 1'b0;
    @(negedge clock);
    check({tag, "_idle_flags"}, {busy[s], done[s], oe[s], rd_n[s], wr_n[s]}, 5'b00011);
    check({tag, "_rdata"}, rdata[s], v.exp_rdata);
    $display("%s: dut%0d we=%0d addr=%h done@%0d strobe=%0d rdata=%h err=%0d",
             tag, s, v.we, v.addr, done_at, strobe_lo, rdata[s], got_err);
  endtask

  initial begin
    int dones, first_done, second_done;
    vec_t v;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = 16'h0; wdata[i] = 8'h0;
      mem_rdata[i] = 8'h0; mem_ready[i] = 1'b0;
    end

    vecs[0] = '{0, 1'b0, 16'h1234, 8'h00, 8'hA5, 32'hFFFF_FFFF, 1, 3, 8'hA5, 1'b0};
    vecs[1] = '{1, 1'b1, 16'hF200, 8'h3C, 8'h77, 32'hFFFF_FFFF, 3, 5, 8'h00, 1'b0};
    vecs[2] = '{0, 1'b0, 16'h00FF, 8'h00, 8'h5A, 32'hFFFF_FFC0, 5, 7, 8'h5A, 1'b0};
    vecs[3] = '{1, 1'b0, 16'hABCD, 8'h00, 8'hC3, 32'hFFFF_FFCC, 5, 7, 8'hC3, 1'b0};
    vecs[4] = '{0, 1'b1, 16'h0001, 8'h81, 8'hEE, 32'hFFFF_FFFF, 1, 3, 8'h5A, 1'b0};
    vecs[5] = '{1, 1'b0, 16'h8000, 8'h00, 8'h3E, 32'hFFFF_FFFF, 3, 5, 8'h3E, 1'b0};

    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst%0d_flags", i), {busy[i], done[i], err[i], oe[i], rd_n[i], wr_n[i]}, 6'b000011);
      check($sformatf("rst%0d_rdata", i), rdata[i], 8'h00);
      check($sformatf("rst%0d_mem_addr", i), mem_addr[i], 16'h0000);
      check($sformatf("rst%0d_mem_wdata", i), mem_wdata[i], 8'h00);
    end

    for (int i = 0; i < 6; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // Back-to-back on the WAIT_STATES=2 instance: pulse while busy is dropped, req in first IDLE cycle is taken.
    dones = 0; first_done = 0; second_done = 0;
    @(negedge clock);
    addr[1] = 16'h1111; we[1] = 1'b0; mem_rdata[1] = 8'h42; mem_ready[1] = 1'b1; req[1] = 1'b1;
    @(posedge clock); #1;
    for (int k = 1; k <= 14; k++) begin
      req[1] = (k == 2) || (k == 6);
      if (k == 2) addr[1] = 16'h2222;
      if (k == 6) addr[1] = 16'h3333;
      @(negedge clock);
      if (done[1] === 1'b1) begin
        dones++;
        if (first_done == 0) first_done = k; else second_done = k;
      end
      if (k == 3) check("b2b_addr_kept", mem_addr[1], 16'h1111);
      if (k == 6) check("b2b_idle_busy", busy[1], 1'b0);
      if (k == 7) check("b2b_accept_busy", busy[1], 1'b1);
      if (k == 7) check("b2b_accept_addr", mem_addr[1], 16'h3333);
      @(posedge clock); #1;
    end
    req[1] = 1'b0;
    check("b2b_done_count", dones, 2);
    check("b2b_first_done", first_done, 5);
    check("b2b_second_done", second_done, 11);
    $display("b2b: dones=%0d at %0d and %0d", dones, first_done, second_done);

    // Asynchronous reset in the middle of a stalled read strobe.
    @(negedge clock);
    addr[0] = 16'h4444; we[0] = 1'b0; mem_ready[0] = 1'b0; req[0] = 1'b1;
    @(posedge clock); #1;
    req[0] = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("rst_mid_strobe_low", rd_n[0], 1'b0);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_rd_n", rd_n[0], 1'b1);
    check("rst_mid_busy", busy[0], 1'b0);
    check("rst_mid_addr", mem_addr[0], 16'h0000);
    check("rst_mid_rdata", rdata[0], 8'h00);
    @(negedge clock);
    reset = 1'b0;
    mem_ready[0] = 1'b1;
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      if (done[0] === 1'b1) dones++;
    end
    check("rst_mid_no_done", dones, 0);
    $display("reset_mid: rd_n=%0d busy=%0d stray_dones=%0d", rd_n[0], busy[0], dones);
    v = '{0, 1'b0, 16'h9999, 8'h00, 8'h66, 32'hFFFF_FFFF, 1, 3, 8'h66, 1'b0};
    run_vec("post_rst", v);

`ifdef BUS_TIMEOUT_EN
    v = '{0, 1'b0, 16'h5555, 8'h00, 8'h11, 32'h0000_0000, 8, 10, 8'hFF, 1'b1};
    run_vec("timeout", v);
`else
    @(negedge clock);
    addr[0] = 16'h5555; we[0] = 1'b0; mem_ready[0] = 1'b0; req[0] = 1'b1;
    @(posedge clock); #1;
    req[0] = 1'b0;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (done[0] === 1'b1) dones++;
    end
    check("stall_busy", busy[0], 1'b1);
    check("stall_strobe", rd_n[0], 1'b0);
    check("stall_no_done", dones, 0);
    $display("stall: busy=%0d rd_n=%0d dones=%0d after 40 cycles", busy[0], rd_n[0], dones);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cpu6_bus_controller.md
Name: cpu6_bus_controller

Overview:
- External memory/peripheral bus cycle controller, directly downstream of the CPU6 core.
- Accepts a single-byte read or write request (address, direction, write data) from the core's bus-access microcode.
- Runs a fixed SETUP/STROBE/HOLD cycle on the external bus, with programmable minimum wait states and a ready handshake.
- Returns read data and a one-cycle completion pulse.

Parameters:
- WAIT_STATES, 0, minimum extra strobe cycles inserted before mem_ready is honoured (0..15).
- TIMEOUT_CYCLES, 255, maximum strobe cycles before abort; used only with BUS_TIMEOUT_EN (1..255).

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  1  request strobe; sampled only while busy=0.
- we  input  1  1=write, 0=read; latched with req.
- addr  input  16  request address; latched with req.
- wdata  input  8  write data; latched with req.
- rdata  output  8  read data; updated only on completion of a read.
- busy  output  1  high from the cycle after req is accepted until the cycle after done.
- done  output  1  one-cycle completion pulse.
- err  output  1  qualified by done; 1 = cycle aborted by timeout.
- mem_addr  output  16  external address; holds the latched address.
- mem_wdata  output  8  external write data.
- mem_wdata_oe  output  1  write-data driver enable; the tri-state buffer is outside this block.
- mem_rdata  input  8  external read data.
- mem_rd_n  output  1  active-low read strobe.
- mem_wr_n  output  1  active-low write strobe.
- mem_ready  input  1  active-high ready from the target; sampled only in STROBE.

Behaviour:
- Clock and reset: one clock, port named clock. Reset port named reset, asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, err=0, rdata=8'h00, mem_addr=16'h0000, mem_wdata=8'h00, mem_wdata_oe=0, mem_rd_n=1, mem_wr_n=1.
- Reset mid-operation: forces the reset values immediately (asynchronously). Strobes deassert without waiting for a clock edge; the aborted cycle never produces done.
- All outputs are registered; no combinational path from any input to any output.
- State machine IDLE -> SETUP -> STROBE -> HOLD -> IDLE:
  - IDLE: on edge with req=1, latch addr/we/wdata into mem_addr/latched_we/mem_wdata and go to SETUP. busy=1 from the next cycle.
  - SETUP: exactly 1 cycle. Address stable, strobes high. mem_wdata_oe=1 if write. Load wait counter with WAIT_STATES. Go to STROBE.
  - STROBE: mem_rd_n=0 (read) or mem_wr_n=0 (write). Wait counter decrements each cycle while nonzero. Exit when counter==0 and mem_ready=1 at the edge; on that edge capture mem_rdata into rdata (reads only) and go to HOLD. mem_ready is ignored while the counter is nonzero.
  - HOLD: exactly 1 cycle. Strobes high, address and write data still driven, mem_wdata_oe still 1 for writes. done=1, err per timeout. Go to IDLE; busy=0 in IDLE.
- Latency, req edge to done-visible cycle: WAIT_STATES+3 cycles minimum, plus 1 per cycle ready is held low after the counter expires.
- Back-to-back: req is accepted in the first IDLE cycle after HOLD, giving a minimum period of WAIT_STATES+4 cycles. req while busy=1 is ignored, not queued.
- rdata is held unchanged across writes and aborted cycles, except the timeout rule below.
- mem_addr and mem_wdata keep their last values in IDLE (no return to zero).
- Strobes are mutually exclusive; both must never be low together.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined: an 8-bit counter clears on entry to STROBE and increments each STROBE cycle. If it reaches TIMEOUT_CYCLES with the exit condition unmet, go to HOLD with done=1 and err=1. For reads, rdata=8'hFF.
- Undefined: STROBE waits indefinitely for mem_ready, err is constant 0, and no counter logic is synthesized.

Test Plan:
- Read, WAIT_STATES=0, mem_ready=1, addr=16'h1234, mem_rdata=8'hA5 -> mem_rd_n low exactly 1 cycle, done 3 cycles after req edge, rdata=8'hA5, mem_wr_n stays high.
- Write, WAIT_STATES=2, addr=16'hF200, wdata=8'h3C -> mem_wr_n low 3 cycles, mem_wdata=8'h3C with mem_wdata_oe=1 from SETUP through HOLD, done at cycle 5, rdata unchanged.
- Read, WAIT_STATES=0, mem_ready low 4 cycles then high -> strobe low 5 cycles, done at cycle 7; mem_ready pulse during the wait-counter window is ignored.
- Second req pulsed while busy=1, then req in first IDLE cycle after HOLD -> first ignored, second accepted; period = WAIT_STATES+4.
- reset asserted mid-STROBE (between edges) -> mem_rd_n=1 immediately, busy=0, no done pulse, next req runs normally.
- BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, read, mem_ready tied 0 -> done with err=1 after 8 strobe cycles, rdata=8'hFF; without macro, busy stays 1 indefinitely.
